mux4_rr_arbiter: RTL

//  Round-robin arbiter and sequencer in front of a 4:1 data mux. Four requesters

---
 rtl/mux4_rr_arbiter.sv | 62 ++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin 4:1 arbiter with lock cap feeding a valid/ready output register
module mux4_rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_LOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             lock,
  output logic [3:0]       gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_LOCK - 1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [1:0] last_q, last_d, sel_q, sel_d, rr, win;
  logic [WIDTH-1:0] data_q, data_d, dsel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic can_load, hold, load;
  always_comb begin
    rr = last_q;
    for (int k = 4; k >= 1; k--)
      if (req[last_q + 2'(k)]) rr = last_q + 2'(k);
    hold = lock && req[last_q] && cnt_q < CAP;
    win = hold ? last_q : rr;
    can_load = state_q == EMPTY || out_ready;
    load = rst_n && can_load && |req;
    gnt = load ? 4'b0001 << win : 4'b0000;
    dsel = win == 2'd0 ? d0 : win == 2'd1 ? d1 : win == 2'd2 ? d2 : d3;
    state_d = load ? FULL : out_ready ? EMPTY : state_q;
    data_d = load ? dsel : data_q;
    sel_d = load ? win : sel_q;
    last_d = load ? win : last_q;
    cnt_d = !load ? cnt_q : (lock && win == last_q) ? (cnt_q == CAP ? cnt_q : cnt_q + 1'b1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q <= '0;
      sel_q <= '0;
      last_q <= 2'd3;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      sel_q <= sel_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = state_q == FULL;
  assign out_data = data_q;
  assign out_sel = sel_q;
endmodule
